pe_sequencer: RTL and testbench

//  Control FSM for one PE (convolver bank + adder tree + non-linearity + pooling).
//  Per tile it clears the line buffers, loads a KxK filter, then streams row_length*num_rows pixels.
//  It drives the PE enables: shifting_*, mac/adder/nl/pool and the pool line-buffer controls.

---
 rtl/pe_sequencer.sv | 101 ++++++++++
 tb/tb_pe_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pe_sequencer.sv
// pe_sequencer: per-tile PE control FSM (clear, filter load, pixel stream, drain), enables and pipeline delay line
module pe_sequencer #(
  parameter int ADDR_W = 8,
  parameter int K = 3,
  parameter int PIPE_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] row_length,
  input  logic [ADDR_W-1:0] num_rows,
  input  logic              final_bank_in,
  input  logic              pool_en_cfg,
  input  logic [2:0]        nl_type_cfg,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              line_buffer_reset,
  output logic              shifting_filter,
  output logic              shifting_line,
  output logic [ADDR_W-1:0] row_length_o,
  output logic              mac_enable,
  output logic              adder_enable,
  output logic              nl_enable,
  output logic [2:0]        nl_type,
  output logic              pool_enable,
  output logic              shifting_line_pool,
  output logic              line_buffer_reset_pool,
  output logic [ADDR_W-1:0] row_length_pool,
  output logic              final_filter_bank,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);
  localparam logic [ADDR_W-1:0] KW = ADDR_W'(K);
  localparam logic [ADDR_W-1:0] KM1 = ADDR_W'(K - 1);
  localparam logic [ADDR_W-1:0] KK = ADDR_W'(K * K);
  localparam logic [ADDR_W-1:0] LAT = ADDR_W'(PIPE_LAT);
  typedef enum logic [2:0] {IDLE, CLR, LD_FILT, STREAM, DRAIN, DONE} state_t;
  state_t state, next;
  logic [ADDR_W-1:0] cnt, col, row, rows_r;
  logic [PIPE_LAT-1:0] dl;
  logic pool_cfg_r, beat, bad, col_end, last_px, launch;
  always_comb begin
    in_ready = state == LD_FILT || state == STREAM;
    beat = in_valid && in_ready;
    bad = row_length < KW || num_rows < KW;
    launch = state == IDLE && start && !bad;
    line_buffer_reset = state == CLR;
    line_buffer_reset_pool = state == CLR;
    shifting_filter = beat && state == LD_FILT;
    shifting_line = beat && state == STREAM;
    mac_enable = shifting_line && col >= KM1 && row >= KM1;
    col_end = col == row_length_o - ADDR_W'(1);
    last_px = col_end && row == rows_r - ADDR_W'(1);
    pool_enable = (state == STREAM || state == DRAIN) && final_filter_bank && pool_cfg_r;
    busy = state != IDLE;
    done = state == DONE;
    next = state;
    case (state)
      IDLE:    next = launch ? CLR : IDLE;
      CLR:     next = LD_FILT;
      LD_FILT: next = shifting_filter && cnt == KK - ADDR_W'(1) ? STREAM : LD_FILT;
      STREAM:  next = shifting_line && last_px ? DRAIN : STREAM;
      DRAIN:   next = cnt == LAT - ADDR_W'(1) ? DONE : DRAIN;
      default: next = IDLE;
    endcase
  end
  // dl[i] is mac_enable delayed by i+1 cycles; it runs freely through stalls
  assign adder_enable = dl[0];
  assign nl_enable = dl[1] && final_filter_bank;
  assign out_valid = dl[PIPE_LAT-1];
  assign shifting_line_pool = nl_enable && pool_enable;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk) begin
    if (rst) begin
      {cnt, col, row, rows_r, row_length_o, row_length_pool} <= '0;
      {dl, pool_cfg_r, final_filter_bank, nl_type, cfg_err} <= '0;
    end else begin
      dl <= {dl[PIPE_LAT-2:0], mac_enable};
      cfg_err <= state == IDLE && start && bad;
      // cnt counts filter beats in LD_FILT and cycles in DRAIN; cleared on every state change
      cnt <= next != state ? '0 : cnt + ADDR_W'(state == LD_FILT ? beat : state == DRAIN);
      if (launch) begin
        row_length_o <= row_length;
        row_length_pool <= row_length - KM1;
        rows_r <= num_rows;
        final_filter_bank <= final_bank_in;
        pool_cfg_r <= pool_en_cfg;
        nl_type <= nl_type_cfg;
        col <= '0;
        row <= '0;
      end else if (shifting_line) begin
        col <= col_end ? '0 : col + ADDR_W'(1);
        row <= row + ADDR_W'(col_end);
      end
    end
  end
endmodule

// File: tb/tb_pe_sequencer.sv
// tb_pe_sequencer: randomized tile traffic checked cycle-by-cycle against a beat-count reference model
module tb_pe_sequencer;
  localparam int K = 3;
  localparam int LAT = 3;
  localparam int MAXC = 1024;
  logic clk = 0, rst = 1, start = 0, final_bank_in = 0, pool_en_cfg = 0, in_valid = 0;
  logic [7:0] row_length = 0, num_rows = 0;
  logic [2:0] nl_type_cfg = 0;
  logic in_ready, line_buffer_reset, shifting_filter, shifting_line, mac_enable, adder_enable, nl_enable;
  logic pool_enable, shifting_line_pool, line_buffer_reset_pool, final_filter_bank, out_valid, busy, done, cfg_err;
  logic [7:0] row_length_o, row_length_pool;
  logic [2:0] nl_type;
  int checks = 0, passed = 0;
  int gd, lov;
  pe_sequencer #(.ADDR_W(8), .K(K), .PIPE_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .row_length(row_length), .num_rows(num_rows),
    .final_bank_in(final_bank_in), .pool_en_cfg(pool_en_cfg), .nl_type_cfg(nl_type_cfg),
    .in_valid(in_valid), .in_ready(in_ready), .line_buffer_reset(line_buffer_reset),
    .shifting_filter(shifting_filter), .shifting_line(shifting_line), .row_length_o(row_length_o),
    .mac_enable(mac_enable), .adder_enable(adder_enable), .nl_enable(nl_enable), .nl_type(nl_type),
    .pool_enable(pool_enable), .shifting_line_pool(shifting_line_pool),
    .line_buffer_reset_pool(line_buffer_reset_pool), .row_length_pool(row_length_pool),
    .final_filter_bank(final_filter_bank), .out_valid(out_valid), .busy(busy), .done(done), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  wire [13:0] sig = {in_ready, line_buffer_reset, line_buffer_reset_pool, shifting_filter, shifting_line,
                     mac_enable, adder_enable, nl_enable, pool_enable, shifting_line_pool, out_valid, busy, done, cfg_err};
  wire [33:0] all_out = {sig, row_length_o, row_length_pool, nl_type, final_filter_bank};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // The model works from beat counts: the first K*K consumed beats are filter,
  // the rest are pixels p = row*rl + col, and everything downstream is a fixed delay.
  task automatic run_tile(input int rl, input int nr, input bit fb, input bit pe, input logic [2:0] nt,
                          input int stall_pct, input int abort_at, input bit noise,
                          output int got_done, output int last_ov);
    bit v[MAXC], rdy[MAXC], sf[MAXC], sl[MAXC], m[MAXC];
    logic [13:0] e;
    int b, t, last, ss, n, dt, p, macs, outs;
    bit nl;
    for (int i = 0; i < MAXC; i++) begin
      v[i] = $urandom_range(99) >= stall_pct;
      {rdy[i], sf[i], sl[i], m[i]} = '0;
    end
    n = K * K + rl * nr;
    b = 0; t = 2; last = 0; ss = 0;
    while (b < n) begin
      rdy[t] = 1;
      if (v[t]) begin
        if (b < K * K) sf[t] = 1;
        else begin
          sl[t] = 1;
          p = b - K * K;
          m[t] = (p / rl) >= K - 1 && (p % rl) >= K - 1;
        end
        if (b == K * K - 1) ss = t + 1;
        b++;
        last = t;
      end
      t++;
    end
    dt = last + LAT + 1;
    macs = 0; outs = 0; got_done = -1; last_ov = -1;
    for (int c = 0; c <= dt + 2; c++) begin
      @(posedge clk);
      #1;
      rst = c == abort_at;
      start = c == 0 || (noise && c >= 1 && c <= dt && $urandom_range(1) == 1);
      in_valid = v[c];
      if (c == 0) begin
        row_length = 8'(rl); num_rows = 8'(nr); final_bank_in = fb; pool_en_cfg = pe; nl_type_cfg = nt;
      end else if (noise) begin
        row_length = 8'($urandom_range(255)); num_rows = 8'($urandom_range(255));
        final_bank_in = 1'($urandom_range(1)); pool_en_cfg = 1'($urandom_range(1)); nl_type_cfg = 3'($urandom_range(7));
      end
      @(negedge clk);
      if (abort_at >= 0 && c == abort_at + 1) begin
        chk("after_rst", all_out, 0);
        rst = 0;
        return;
      end
      nl = c >= 2 && m[c-2] && fb;
      e = {rdy[c], c == 1, c == 1, sf[c], sl[c], m[c], c >= 1 && m[c-1], nl,
           fb && pe && c >= ss && c <= last + LAT, nl && pe && c >= ss && c <= last + LAT,
           c >= 3 && m[c-3], c >= 1 && c <= dt, c == dt, 1'b0};
      chk($sformatf("cyc%0d", c), sig, e);
      if (c == 1) chk("cfg", {row_length_o, row_length_pool, nl_type, final_filter_bank}, {8'(rl), 8'(rl - K + 1), nt, fb});
      macs += int'(mac_enable);
      outs += int'(out_valid);
      if (out_valid) last_ov = c;
      if (done) got_done = c;
    end
    chk("mac_count", macs, (nr - K + 1) * (rl - K + 1));
    chk("out_count", outs, (nr - K + 1) * (rl - K + 1));
    chk("done_cycle", got_done, dt);
  endtask

  task automatic run_bad(input int rl, input int nr);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      start = c == 0;
      row_length = 8'(rl); num_rows = 8'(nr);
      final_bank_in = 1; pool_en_cfg = 1;
      in_valid = 1'($urandom_range(1));
      @(negedge clk);
      chk($sformatf("bad%0d", c), sig, {13'b0, c == 1});
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", all_out, 0);
    rst = 0;
    run_tile(5, 5, 1, 1, 3'd5, 0, -1, 0, gd, lov);
    chk("t1_done", gd, 39);
    chk("t1_last_ov", lov, 38);
    run_tile(5, 5, 1, 1, 3'd2, 34, -1, 0, gd, lov);
    run_bad(2, 5);
    run_bad(5, 2);
    run_bad(0, 0);
    run_tile(5, 5, 0, 1, 3'd1, 0, -1, 0, gd, lov);
    run_tile(5, 5, 1, 1, 3'd3, 0, 22, 0, gd, lov);
    run_tile(5, 5, 1, 1, 3'd3, 0, -1, 0, gd, lov);
    chk("t5_done", gd, 39);
    run_tile(5, 5, 1, 1, 3'd6, 0, -1, 1, gd, lov);
    chk("t6_done", gd, 39);
    run_tile(K, K, 1, 0, 3'd4, 20, -1, 1, gd, lov);
    for (int i = 0; i < 8; i++)
      run_tile($urandom_range(8, K), $urandom_range(8, K), 1'($urandom_range(1)), 1'($urandom_range(1)),
               3'($urandom_range(7)), $urandom_range(40), i == 3 ? 30 : -1, 1'($urandom_range(1)), gd, lov);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
